// File: rtl/clk_meter_pkg.sv
// Shared types and helpers for the clock period meter.
package clk_meter_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STALL
  } meter_state_t;

  // One extra bit keeps the magnitude exact for any operand pair.
  function automatic logic [32:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level into clk_in and emits a registered
// one-cycle pulse on each rising edge; level is the edge-aligned history flop.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   edge_reg;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
      edge_reg <= 1'b0;
    end else begin
      sync_reg[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      hist_reg <= sync_reg[SYNC_STAGES-1];
      edge_reg <= sync_reg[SYNC_STAGES-1] & ~hist_reg;
    end
  end

  assign level      = hist_reg;
  assign edge_pulse = edge_reg;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow clock in clk_in cycles with lock/stall status.
// Define CLK_METER_HIGHTIME_EN to also report the high time of each period.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PERIOD  = 65535,
  parameter int TOL         = 0,
  parameter int LOCK_N      = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clk_meas,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             stalled
);

  localparam int                LOCK_W    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_N);

  // Reset asserts asynchronously but releases on a clk_in edge.
  logic [1:0] rst_sync_reg;
  logic       rst_int_n;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_int_n = rst_sync_reg[1];

  logic meas_level;
  logic meas_edge;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_in    (clk_in),
    .rst_n     (rst_int_n),
    .async_in  (clk_meas),
    .level     (meas_level),
    .edge_pulse(meas_edge)
  );

  meter_state_t      state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  period_reg;
  logic              period_valid_reg;
  logic              locked_reg;
  logic              stalled_reg;
  logic              prev_ok_reg;
  logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic              measure_done;
  logic              stall_hit;
  logic              stable;
  logic [32:0]       diff;

  assign diff   = abs_diff(32'(period_reg), 32'(cnt_reg));
  assign stable = prev_ok_reg && (diff <= 33'(TOL));

  always_ff @(posedge clk_in or negedge rst_int_n) begin
    if (!rst_int_n) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    measure_done  = 1'b0;
    stall_hit     = 1'b0;
    lock_cnt_next = lock_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (meas_edge) state_next = MEASURE;
      end
      MEASURE: begin
        // An edge arriving on the saturation cycle still counts as a measurement.
        if (meas_edge) begin
          measure_done = 1'b1;
        end else if (cnt_reg == MAX_CNT) begin
          stall_hit  = 1'b1;
          state_next = STALL;
        end
      end
      STALL: begin
        if (meas_edge) state_next = MEASURE;
      end
      default: state_next = IDLE;
    endcase

    if (stall_hit) begin
      lock_cnt_next = '0;
    end else if (measure_done) begin
      if (!stable)                     lock_cnt_next = '0;
      else if (lock_cnt_reg != LOCK_FULL) lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt_reg          <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      locked_reg       <= 1'b0;
      stalled_reg      <= 1'b0;
      prev_ok_reg      <= 1'b0;
      lock_cnt_reg     <= '0;
    end else begin
      period_valid_reg <= measure_done;
      lock_cnt_reg     <= lock_cnt_next;
      locked_reg       <= (lock_cnt_next == LOCK_FULL);

      if (meas_edge)                                       cnt_reg <= ONE;
      else if (state_reg == MEASURE && cnt_reg != MAX_CNT) cnt_reg <= cnt_reg + ONE;

      if (measure_done) begin
        period_reg  <= cnt_reg;
        prev_ok_reg <= 1'b1;
      end

      // The interval that ran into a stall is discarded, so the next one cannot be stable.
      if (stall_hit) begin
        stalled_reg <= 1'b1;
        prev_ok_reg <= 1'b0;
      end else if (meas_edge) begin
        stalled_reg <= 1'b0;
      end
    end
  end

`ifdef CLK_METER_HIGHTIME_EN
  logic [CNT_W-1:0] hcnt_reg;
  logic [CNT_W-1:0] high_time_reg;

  always_ff @(posedge clk_in or negedge rst_int_n) begin
    if (!rst_int_n) begin
      hcnt_reg      <= '0;
      high_time_reg <= '0;
    end else begin
      if (meas_edge)                              hcnt_reg <= CNT_W'(meas_level);
      else if (meas_level && hcnt_reg != MAX_CNT) hcnt_reg <= hcnt_reg + ONE;
      if (measure_done) high_time_reg <= hcnt_reg;
    end
  end

  assign high_time = high_time_reg;
`else
  logic unused_level;
  assign unused_level = meas_level;
  assign high_time    = '0;
`endif

  assign period       = period_reg;
  assign period_valid = period_valid_reg;
  assign locked       = locked_reg;
  assign stalled      = stalled_reg;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized scoreboard bench for clk_period_meter against an edge-time model.
module tb_clk_period_meter;

  localparam int CNT_W  = 16;
  localparam int SYNC   = 2;
  localparam int MAXP   = 200;
  localparam int TOL    = 1;
  localparam int LOCK_N = 4;
  localparam int LAT    = SYNC + 2;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             clk_meas = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [CNT_W-1:0] high_time;
  logic             locked;
  logic             stalled;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .MAX_PERIOD (MAXP),
    .TOL        (TOL),
    .LOCK_N     (LOCK_N)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .clk_meas    (clk_meas),
    .period      (period),
    .period_valid(period_valid),
    .high_time   (high_time),
    .locked      (locked),
    .stalled     (stalled)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int per;
    int high;
    bit lck;
  } exp_t;

  exp_t exp_q[$];
  int   edges[$];
  int   plist[$];
  bit   have_prev;
  int   prev_t;
  int   prev_h;
  int   last_period;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    edges.delete();
    plist.delete();
    exp_q.delete();
    have_prev   = 0;
    last_period = 0;
  endtask

  // Each input rising edge closes the interval opened by the previous one;
  // intervals longer than MAXP are lost to a stall and restart the history.
  task automatic model_edge(input int t, input int h);
    exp_t e;
    int   n;
    int   d;
    if (have_prev && (t - prev_t) <= MAXP) begin
      e.per = t - prev_t;
      plist.push_back(e.per);
      n     = plist.size();
      e.lck = (n >= LOCK_N + 1);
      for (int i = n - LOCK_N; i < n && i > 0; i++) begin
        d = plist[i] - plist[i-1];
        if (d < 0) d = -d;
        if (d > TOL) e.lck = 0;
      end
      e.cyc = t + LAT;
`ifdef CLK_METER_HIGHTIME_EN
      e.high = prev_h;
`else
      e.high = 0;
`endif
      exp_q.push_back(e);
      last_period = e.per;
    end else begin
      plist.delete();
    end
    prev_t    = t;
    prev_h    = h;
    have_prev = 1;
    edges.push_back(t);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic pulse(input int h, input int l);
    model_edge(cyc, h);
    clk_meas = 1'b1;
    wait_cycles(h);
    clk_meas = 1'b0;
    wait_cycles(l);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_valid"}, period_valid, 0);
    chk({tag, "_high"}, high_time, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_stalled"}, stalled, 0);
  endtask

  task automatic reset_mid();
    wait_cycles(LAT + 2);
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_zero("reset_mid");
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    wait_cycles(4);
  endtask

  // Monitor: pops an expectation exactly on its cycle, otherwise demands silence.
  always @(negedge clk_in) begin
    exp_t e;
    bit   exp_st;
    while (edges.size() > 1 && edges[1] + LAT <= cyc) void'(edges.pop_front());
    exp_st = (edges.size() > 0) && (edges[0] + LAT <= cyc) && (cyc >= edges[0] + LAT + MAXP);
    chk("stalled", stalled, exp_st);
    if (exp_st) begin
      chk("stall_locked", locked, 0);
      chk("stall_period_hold", period, last_period);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("period_valid", period_valid, 1);
      chk("period", period, e.per);
      chk("high_time", high_time, e.high);
      chk("locked", locked, e.lck);
      $display("valid cyc=%0d period=%0d high=%0d locked=%0b (model %0d/%0d/%0b)",
               cyc, period, high_time, locked, e.per, e.high, e.lck);
    end else begin
      chk("period_valid_idle", period_valid, 0);
    end
  end

  initial begin
    int h;
    int l;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #1 chk_zero("reset");
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    wait_cycles(4);

    repeat (8) pulse(2, 2);
    pulse(2, MAXP + 50);
    repeat (6) pulse(5, 5);
    pulse(5, MAXP - 5);
    pulse(5, MAXP - 4);
    repeat (3) pulse(5, 5);
    repeat (5) begin
      pulse(4, 4);
      pulse(4, 5);
    end
    repeat (5) begin
      pulse(4, 4);
      pulse(5, 5);
    end
    repeat (6) pulse(3, 3);
    reset_mid();
    repeat (6) pulse(3, 3);

    for (int i = 0; i < 60; i++) begin
      h = $urandom_range(1, 8);
      l = $urandom_range(1, 12);
      if ($urandom_range(0, 9) == 0) l = MAXP - h + $urandom_range(0, 2);
      pulse(h, l);
      if ($urandom_range(0, 19) == 0) reset_mid();
    end

    reset_mid();
    pulse(3, 3);
    wait_cycles(MAXP + 20);
    chk("single_edge_stalled", stalled, 1);
    wait_cycles(LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
